// File: rtl/store_buffer.sv
// Store buffer between the processor and backing memory: a circular FIFO of stores that
// drains in order. Loads are forwarded from the newest buffered store to the same word.
module sbLane #(
  parameter int WIDTH = 32,
  parameter int CW    = 3,
  parameter int AGE   = 0
) (
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] entryAddr,
  input  logic [WIDTH-1:0] loadAddr,
  output logic             hit
);
  // AGE is the distance from head. The lane is live only while that distance is below count.
  assign hit = (CW'(AGE) < count) && (entryAddr[WIDTH-1:2] == loadAddr[WIDTH-1:2]);
endmodule

module store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwriteM,
  input  logic [WIDTH-1:0] aluresultM,
  input  logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] readdataM,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_wready,
  output logic             sb_full,
  output logic             sb_empty,
  output logic             sb_overflow
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } sbEntry_t;

  sbEntry_t      entries [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          overflow;
  logic          push, pop;

  logic [DEPTH-1:0]            laneHit;
  logic [DEPTH-1:0][WIDTH-1:0] laneData;

  assign sb_empty    = (count == '0);
  assign sb_full     = (count == (PW+1)'(DEPTH));
  assign sb_overflow = overflow;
  assign mem_we      = !sb_empty;
  assign mem_waddr   = entries[head].addr;
  assign mem_wdata   = entries[head].data;

  assign pop  = mem_we && mem_wready;
  // A full buffer still takes a store when a slot frees on the same edge.
  assign push = memwriteM && (!sb_full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (memwriteM && !push) overflow <= 1'b1;
    end
  end

  // Entry storage is unreset. The count gates every use, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{addr: aluresultM, data: writedataM};
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gLane
    logic [PW-1:0] laneIdx;
    assign laneIdx     = head + PW'(g);
    assign laneData[g] = entries[laneIdx].data;
    sbLane #(.WIDTH(WIDTH), .CW(PW+1), .AGE(g)) uLane (
      .count    (count),
      .entryAddr(entries[laneIdx].addr),
      .loadAddr (aluresultM),
      .hit      (laneHit[g])
    );
  end

  // Lanes run oldest to newest, so the last hit wins. That hit is the newest matching store.
  always_comb begin
    readdataM = mem_rdata;
    for (int k = 0; k < DEPTH; k++)
      if (laneHit[k]) readdataM = laneData[k];
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the data and address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the number of buffered store entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port memwriteM, input, 1 bit: processor store request for the current cycle.
REQ-006 The block SHALL have port aluresultM, input, WIDTH bits: processor byte address for the load or store.
REQ-007 The block SHALL have port writedataM, input, WIDTH bits: processor store data.
REQ-008 The block SHALL have port readdataM, output, WIDTH bits: load data returned to the processor.
REQ-009 The block SHALL have port mem_rdata, input, WIDTH bits: combinational read data from backing memory, addressed by aluresultM.
REQ-010 The block SHALL have port mem_we, output, 1 bit: write request to backing memory.
REQ-011 The block SHALL have port mem_waddr, output, WIDTH bits: write address to backing memory.
REQ-012 The block SHALL have port mem_wdata, output, WIDTH bits: write data to backing memory.
REQ-013 The block SHALL have port mem_wready, input, 1 bit: memory accepts the write presented this cycle.
REQ-014 The block SHALL have port sb_full, output, 1 bit: buffer holds DEPTH entries.
REQ-015 The block SHALL have port sb_empty, output, 1 bit: buffer holds 0 entries.
REQ-016 The block SHALL have port sb_overflow, output, 1 bit: sticky flag, set when a store was dropped.

Function
REQ-017 The block SHALL implement a circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0, and a count of log2(DEPTH)+1 bits.
REQ-018 The block SHALL define a push as memwriteM=1 at a rising edge while the block can accept; a pushed entry is {aluresultM, writedataM} written at tail, and tail then increments.
REQ-019 The block SHALL drive mem_we = !sb_empty, with mem_waddr/mem_wdata equal to the head entry, combinationally from state.
REQ-020 The block SHALL define a pop as mem_we=1 and mem_wready=1 at a rising edge; head then increments, and the entry is written exactly once to memory in FIFO order.
REQ-021 The block SHALL, on simultaneous push and pop, keep count unchanged, including when the buffer is full: the push is accepted because a slot frees in the same edge.
REQ-022 The block SHALL, on push while full without a pop, drop the store, leave the FIFO unchanged, and set sb_overflow to 1 until reset.
REQ-023 The block SHALL set sb_full = (count==DEPTH) and sb_empty = (count==0), both combinationally from state.
REQ-024 The block SHALL compare loads on word address, bits [WIDTH-1:2]; byte offsets are ignored.
REQ-025 The block SHALL drive readdataM with the data of the newest valid entry whose word address matches aluresultM, else mem_rdata; this path is combinational with zero latency.
REQ-026 The block SHALL include the entry being popped in the same cycle in the match set, so forwarding is never lost during drain.
REQ-027 The block SHALL NOT forward a store being pushed in the same cycle, since that entry is not yet valid.
REQ-028 The block SHALL NOT let mem_wready affect state while sb_empty=1.

Reset
REQ-029 The block SHALL, while rst=0 and independent of clk, set head=0, tail=0, count=0, and sb_overflow=0, giving sb_empty=1, sb_full=0, and mem_we=0.
REQ-030 The block SHALL NOT require entry storage to be reset; stale entries SHALL never forward or drain after reset.
REQ-031 The block SHALL, on reset assertion mid-operation, discard all pending stores with no further mem_we.
REQ-032 The block SHALL, on reset deassertion, accept a push on the first rising edge.

Verification
REQ-033 The bench SHALL cover: store 0x100<-0xAAAA5555 with mem_wready=0 -> next cycle mem_we=1, mem_waddr=0x100, mem_wdata=0xAAAA5555, sb_empty=0.
REQ-034 The bench SHALL cover: stores 0x10<-1 then 0x10<-2, then load 0x12 with mem_rdata=0xDEAD -> readdataM=2.
REQ-035 The bench SHALL cover: 4 stores with mem_wready=0 -> sb_full=1; a 5th store -> dropped, sb_overflow=1, count 4; then mem_wready=1 drains in order 4 writes -> sb_empty=1.
REQ-036 The bench SHALL cover: full buffer, push with mem_wready=1 in the same cycle -> count stays 4, sb_overflow stays 0, new entry drains last.
REQ-037 The bench SHALL cover: 6 push/pop cycles so pointers wrap, then load of an unmatched address -> readdataM=mem_rdata.
REQ-038 The bench SHALL cover: 3 entries pending, rst pulled low between edges -> immediately mem_we=0 and sb_empty=1; a load of a previously buffered address returns mem_rdata.
